// File: rtl/pc_lut_pkg.sv
// Shared types and default widths for the programmable PC target table.
package pc_lut_pkg;

  localparam int unsigned PC_W  = 12;
  localparam int unsigned IDX_W = 6;

  typedef enum logic {MODE_REL = 1'b0, MODE_ABS = 1'b1} tgt_mode_e;

  typedef enum logic {ST_INIT, ST_READY} tbl_state_e;

endpackage

// File: rtl/pc_target_mem.sv
// DEPTH x (D+1) entry storage: one synchronous write port and one
// asynchronous read port that returns same-cycle write data on an address match.
module pc_target_mem
  import pc_lut_pkg::*;
#(
  parameter int unsigned D  = PC_W,
  parameter int unsigned AW = IDX_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [D:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [D:0]    rd_data_c
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [D:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Write-first: a lookup of the entry being written sees the new contents.
  assign rd_data_c = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/pc_target_table.sv
// Runtime-programmable branch-target table: clears itself after reset, then
// resolves REL/ABS entries to a next PC with one cycle of registered latency.
module pc_target_table
  import pc_lut_pkg::*;
#(
  parameter int unsigned D  = PC_W,
  parameter int unsigned AW = IDX_W
) (
  input  logic          Clk,
  input  logic          Reset_n,
  output logic          busy,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [D-1:0]  wr_data,
  input  logic          wr_abs,
  input  logic          lu_req,
  input  logic [AW-1:0] lu_addr,
  input  logic [D-1:0]  pc_in,
  output logic          lu_valid,
  output logic [D-1:0]  target,
  output logic          hit
);

  localparam int unsigned DEPTH = 2 ** AW;

  tbl_state_e       state_q, state_d;
  logic [AW-1:0]    cnt_q;
  logic [DEPTH-1:0] written_q;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [D:0]       mem_wdata;
  logic [D:0]       rd_entry_c;

  tgt_mode_e        rd_mode_c;
  logic [D-1:0]     rd_val_c;
  logic [D-1:0]     target_c;
  logic             hit_c;
  logic             ready_c;

  // Next state and memory write-port steering: sweep owns the port while clearing.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = {wr_abs, wr_data};
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (cnt_q == AW'(DEPTH - 1)) state_d = ST_READY;
      end
      ST_READY: begin
        mem_we = wr_en;
      end
    endcase
  end

  pc_target_mem #(
    .D  (D),
    .AW (AW)
  ) u_mem (
    .clk       (Clk),
    .we        (mem_we),
    .waddr     (mem_waddr),
    .wdata     (mem_wdata),
    .raddr     (lu_addr),
    .rd_data_c (rd_entry_c)
  );

  assign ready_c   = (state_q == ST_READY);
  assign rd_mode_c = tgt_mode_e'(rd_entry_c[D]);
  assign rd_val_c  = rd_entry_c[D-1:0];
  assign target_c  = (rd_mode_c == MODE_ABS) ? rd_val_c : D'(pc_in + rd_val_c);
  assign hit_c     = written_q[lu_addr] | (wr_en && (wr_addr == lu_addr));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      written_q <= '0;
      busy      <= 1'b1;
      lu_valid  <= 1'b0;
      target    <= '0;
      hit       <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy     <= (state_d == ST_INIT);
      lu_valid <= ready_c && lu_req;
      if (!ready_c) cnt_q <= cnt_q + AW'(1);
      if (ready_c && wr_en) written_q[wr_addr] <= 1'b1;
      // target/hit hold between lookups.
      if (ready_c && lu_req) begin
        target <= target_c;
        hit    <= hit_c;
      end
    end
  end

endmodule

// File: tb/tb_pc_target_table.sv
// Self-checking bench: directed spec scenarios plus randomized traffic against
// a behavioural table model that counts cycles since reset release.
module tb_pc_target_table;

  localparam int NENT = 64;

  logic        Clk;
  logic        Reset_n;
  logic        busy;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_abs;
  logic        lu_req;
  logic [5:0]  lu_addr;
  logic [11:0] pc_in;
  logic        lu_valid;
  logic [11:0] target;
  logic        hit;

  int checks = 0;
  int errors = 0;

  pc_target_table dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_abs   (wr_abs),
    .lu_req   (lu_req),
    .lu_addr  (lu_addr),
    .pc_in    (pc_in),
    .lu_valid (lu_valid),
    .target   (target),
    .hit      (hit)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the table is usable once 64 clean cycles have elapsed.
  bit          model_on = 0;
  int          since_rel = 0;
  bit          m_abs [NENT];
  logic [11:0] m_val [NENT];
  bit          m_wr  [NENT];
  logic        e_busy, e_valid, e_hit;
  logic [11:0] e_target;

  always @(posedge Clk) begin
    if (!Reset_n) begin
      model_on  = 1;
      since_rel = 0;
      for (int i = 0; i < NENT; i++) begin
        m_abs[i] = 0;
        m_val[i] = '0;
        m_wr[i]  = 0;
      end
      e_busy = 1; e_valid = 0; e_target = '0; e_hit = 0;
    end else begin
      e_valid = 0;
      if (since_rel >= NENT) begin
        if (wr_en) begin
          m_abs[wr_addr] = wr_abs;
          m_val[wr_addr] = wr_data;
          m_wr[wr_addr]  = 1;
        end
        if (lu_req) begin
          e_valid  = 1;
          e_hit    = m_wr[lu_addr];
          e_target = m_abs[lu_addr] ? m_val[lu_addr] : 12'(pc_in + m_val[lu_addr]);
        end
      end
      if (since_rel < 100000) since_rel++;
      e_busy = (since_rel < NENT);
    end
  end

  always @(negedge Clk) begin
    if (model_on) begin
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_valid", 32'(lu_valid), 32'(e_valid));
      chk("m_target", 32'(target), 32'(e_target));
      chk("m_hit", 32'(hit), 32'(e_hit));
    end
  end

  task automatic idle();
    wr_en  = 0;
    lu_req = 0;
  endtask

  task automatic op(input logic we, input logic [5:0] wa, input logic [11:0] wd, input logic wab,
                    input logic rq, input logic [5:0] la, input logic [11:0] pc);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_abs = wab;
    lu_req = rq; lu_addr = la; pc_in = pc;
    @(posedge Clk); #2;
    idle();
  endtask

  task automatic rand_inputs(input bit allow_reset);
    wr_en   = 1'($urandom_range(0, 1));
    wr_addr = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
    wr_data = 12'($urandom);
    wr_abs  = 1'($urandom_range(0, 1));
    lu_req  = 1'($urandom_range(0, 3) != 0);
    lu_addr = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
    pc_in   = 12'($urandom);
    Reset_n = !(allow_reset && ($urandom_range(0, 599) == 0));
  endtask

  task automatic sweep_check(input string name, input bit poke3);
    for (int k = 1; k <= NENT; k++) begin
      if (k < NENT) begin
        rand_inputs(0);
        if (poke3) begin wr_en = 1; wr_addr = 6'd3; end
      end else idle();
      @(posedge Clk); #2;
      chk(name, 32'(busy), 32'(k < NENT));
      chk({name, "_valid"}, 32'(lu_valid), 32'd0);
    end
    idle();
  endtask

  initial begin
    Reset_n = 0;
    idle();
    wr_addr = '0; wr_data = '0; wr_abs = 0; lu_addr = '0; pc_in = '0;

    // Reset held three cycles, then the clearing sweep.
    repeat (3) @(posedge Clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_valid", 32'(lu_valid), 32'd0);
    chk("rst_target", 32'(target), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    Reset_n = 1;
    sweep_check("sweep_busy", 0);

    // REL positive offset.
    op(1, 6'd0, 12'd6, 0, 0, 6'd0, 12'd0);
    op(0, 6'd0, 12'd0, 0, 1, 6'd0, 12'd100);
    chk("rel_valid", 32'(lu_valid), 32'd1);
    chk("rel_target", 32'(target), 32'd106);
    chk("rel_hit", 32'(hit), 32'd1);

    // Negative offset, then wrap below zero (back-to-back lookups).
    op(1, 6'd1, 12'hFF7, 0, 0, 6'd0, 12'd0);
    op(0, 6'd0, 12'd0, 0, 1, 6'd1, 12'd20);
    chk("neg_target", 32'(target), 32'd11);
    op(0, 6'd0, 12'd0, 0, 1, 6'd1, 12'd5);
    chk("wrap_valid", 32'(lu_valid), 32'd1);
    chk("wrap_target", 32'(target), 32'hFFC);

    // ABS entry and an unwritten entry.
    op(1, 6'd63, 12'h3A0, 1, 0, 6'd0, 12'd0);
    op(0, 6'd0, 12'd0, 0, 1, 6'd63, 12'd7);
    chk("abs_target", 32'(target), 32'h3A0);
    chk("abs_hit", 32'(hit), 32'd1);
    op(0, 6'd0, 12'd0, 0, 1, 6'd2, 12'd50);
    chk("unwr_target", 32'(target), 32'd50);
    chk("unwr_hit", 32'(hit), 32'd0);

    // Same-cycle write and lookup of one entry: write-first.
    op(1, 6'd5, 12'd200, 1, 1, 6'd5, 12'd9);
    chk("coll_target", 32'(target), 32'd200);
    chk("coll_hit", 32'(hit), 32'd1);
    @(posedge Clk); #2;
    chk("hold_valid", 32'(lu_valid), 32'd0);
    chk("hold_target", 32'(target), 32'd200);
    chk("hold_hit", 32'(hit), 32'd1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rand_inputs(1);
      @(posedge Clk); #2;
    end
    Reset_n = 1;
    idle();
    repeat (NENT + 2) @(posedge Clk);
    #2;

    // Reset in the middle of a sweep, with writes to idx3 while busy.
    Reset_n = 0;
    @(posedge Clk); #2;
    Reset_n = 1;
    for (int k = 0; k < 30; k++) begin
      wr_en = 1; wr_addr = 6'd3; wr_data = 12'h123; wr_abs = 1; lu_req = 1; lu_addr = 6'd3;
      @(posedge Clk); #2;
    end
    chk("mid_busy", 32'(busy), 32'd1);
    Reset_n = 0;
    @(posedge Clk); #2;
    Reset_n = 1;
    sweep_check("resweep_busy", 1);
    op(0, 6'd0, 12'd0, 0, 1, 6'd3, 12'd77);
    chk("ign_valid", 32'(lu_valid), 32'd1);
    chk("ign_hit", 32'(hit), 32'd0);
    chk("ign_target", 32'(target), 32'd77);

    repeat (2) @(posedge Clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
